ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: the sending side of the PS/2 link whose receive side
//  the mouse unit already implements. Sends one command byte to the mouse (e.g. 0xF4,
//  enable data reporting) over the shared open-drain ps2c/ps2d pair.
//  Sits beside the mouse receiver in the 50 MHz domain; tx_idle gates the receiver.
// PARAMETERS
//  CLK_HZ        50_000_000  system clock frequency
//  RTS_CYCLES    5000        cycles ps2c is held low for request-to-send (100 us @ 50 MHz)
//  TIMEOUT_CYCLES 750000     watchdog per transfer after RTS (15 ms @ 50 MHz)
//  FILTER_LEN    8           ps2c glitch filter depth (samples)
// PORTS
//  clk           in   1  system clock (50 MHz)
//  reset         in   1  synchronous, active-high reset
//  wr_ps2        in   1  1-cycle strobe: start transmission of din
//  din           in   8  command byte, captured on accepted wr_ps2
//  ps2c          inout 1 PS/2 clock, open drain (drive 0 or Z only)
//  ps2d          inout 1 PS/2 data, open drain (drive 0 or Z only)
//  tx_idle       out  1  1 when in IDLE; receiver is enabled only while high
//  tx_done_tick  out  1  1-cycle pulse: byte sent and device ACK seen (ps2d=0)
//  tx_err_tick   out  1  1-cycle pulse: watchdog expired or ACK missing (ps2d=1)
// BEHAVIOUR
//  Reset: state=IDLE, ps2c/ps2d released (Z), tx_idle=1, done/err ticks=0, counters=0,
//   filter register=all ones, filtered clock=1.
//  Clock filter: shift ps2c into FILTER_LEN-bit register; filtered=1 when all ones,
//   0 when all zeros, else hold. fall_edge = filtered 1->0, one cycle wide.
//  Frame: start(0), din[0..7] LSB first, odd parity (~^din), stop(1), device ACK.
//  FSM (one transition max per clk):
//   IDLE : wr_ps2=1 -> latch {par,din} into 9-bit shift reg, rts counter=RTS_CYCLES-1,
//          -> RTS. wr_ps2 in any other state is ignored (no queueing).
//   RTS  : drive ps2c=0; counter decrements; at 0 -> START. Watchdog cleared here.
//   START: release ps2c, drive ps2d=0; fall_edge -> DATA, bit counter n=8.
//   DATA : drive ps2d=0 when shift[0]=0 else Z; on fall_edge shift right;
//          n=0 at fall_edge -> STOP, else n--. 9 bits total (8 data + parity).
//   STOP : release ps2d; fall_edge -> ACK.
//   ACK  : wait fall_edge; sample filtered-synchronised ps2d: 0 -> tx_done_tick,
//          1 -> tx_err_tick; both -> IDLE.
//  Watchdog: counts every cycle in START..ACK; reaching TIMEOUT_CYCLES -> release both
//   lines, tx_err_tick=1, -> IDLE (takes priority over fall_edge in the same cycle).
//  Ticks asserted only in the cycle of the transition into IDLE; never both at once.
//  ps2d sampled through a 2-flop synchroniser; ps2c via synchroniser then filter.
//  Reset mid-frame: lines released next clock, FSM to IDLE; the device times out on its own.
//  tx_idle is combinational from state (=1 only in IDLE).
// STRUCTURE
//  Shared package/header: PS/2 state encodings (IDLE,RTS,START,DATA,STOP,ACK),
//   command constants (PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF), RTS/timeout
//   defaults; counter widths via $clog2.
//  One sub-module: ps2_clk_filter (synchroniser + FILTER_LEN filter + fall_edge), reusable
//   by the mouse receiver. Tri-states (assign ps2c = drv_c ? 1'b0 : 1'bz) live in this
//   block only.
// TESTING (bench models a PS/2 device with pullups, 40 us clock period)
//  1 wr_ps2 with din=8'hF4 -> ps2c low >=5000 cycles; device samples 0,0,0,1,0,1,1,1,1,
//    parity 0, stop 1; device ACK -> single tx_done_tick, tx_idle back to 1.
//  2 din=8'hFF -> parity bit 1 sampled; din=8'h00 -> parity bit 1; din=8'h01 -> parity 0.
//  3 Device never clocks after RTS -> tx_err_tick exactly TIMEOUT_CYCLES after RTS end,
//    both lines Z.
//  4 Device leaves ps2d high in ACK slot -> tx_err_tick, no tx_done_tick.
//  5 Second wr_ps2 mid-frame (din=8'hAA) -> ignored; frame still carries first byte.
//  6 reset asserted during DATA bit 4 -> next clk lines Z, tx_idle=1, no ticks; 1-3 cycle
//    glitches on ps2c during DATA produce no extra shifts.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host transmitter definitions: state codes, command bytes
// and timing defaults for the 50 MHz mouse domain.
package ps2_host_tx_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RTS   = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;
    localparam logic [2:0] ST_ACK   = 3'd5;

    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;

    localparam int PS2_CLK_HZ     = 50_000_000;
    localparam int PS2_RTS_US     = 100;
    localparam int PS2_TIMEOUT_MS = 15;
    localparam int PS2_FILTER_LEN = 8;

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioner: 2-flop synchroniser, all-ones/all-zeros
// glitch filter and a one-cycle falling-edge strobe.
module ps2_clk_filter
    import ps2_host_tx_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c_in,
    output logic fall_edge
);

    logic [1:0]            sync_q, sync_d;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  f_q, f_d;

    always_comb begin
        sync_d = {sync_q[0], ps2c_in};
        filt_d = {filt_q[FILTER_LEN-2:0], sync_q[1]};
        f_d    = f_q;
        // mixed history keeps the previous level
        if (&filt_q) begin
            f_d = 1'b1;
        end else if (~|filt_q) begin
            f_d = 1'b0;
        end
    end

    assign fall_edge = f_q & ~f_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            filt_q <= '1;
            f_q    <= 1'b1;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            f_q    <= f_d;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame
// clocked by the device, ACK check and per-transfer watchdog.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLK_HZ         = PS2_CLK_HZ,
    parameter int RTS_CYCLES     = CLK_HZ / 1_000_000 * PS2_RTS_US,
    parameter int TIMEOUT_CYCLES = CLK_HZ / 1000 * PS2_TIMEOUT_MS,
    parameter int FILTER_LEN     = PS2_FILTER_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);

    localparam int RW = $clog2(RTS_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RW-1:0] RTS_LOAD = RW'(RTS_CYCLES - 1);
    localparam logic [WW-1:0] WDT_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [8:0]    shift_q, shift_d;
    logic [3:0]    n_q, n_d;
    logic [RW-1:0] rts_q, rts_d;
    logic [WW-1:0] wdt_q, wdt_d;
    logic [1:0]    dsync_q, dsync_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          fall_edge;
    logic          drv_c, drv_d;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2c_in  (ps2c),
        .fall_edge(fall_edge)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        n_d     = n_q;
        rts_d   = rts_q;
        wdt_d   = '0;
        dsync_d = {dsync_q[0], ps2d};
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_ps2) begin
                    shift_d = {~^din, din};
                    rts_d   = RTS_LOAD;
                    state_d = ST_RTS;
                end
            end
            ST_RTS: begin
                if (rts_q == '0) begin
                    state_d = ST_START;
                end else begin
                    rts_d = rts_q - 1'b1;
                end
            end
            ST_START, ST_DATA, ST_STOP, ST_ACK: begin
                wdt_d = wdt_q + 1'b1;
                // watchdog wins over a coincident clock edge
                if (wdt_q == WDT_LAST) begin
                    wdt_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (fall_edge) begin
                    if (state_q == ST_START) begin
                        n_d     = 4'd8;
                        state_d = ST_DATA;
                    end else if (state_q == ST_DATA) begin
                        shift_d = {1'b0, shift_q[8:1]};
                        if (n_q == 4'd0) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q - 1'b1;
                        end
                    end else if (state_q == ST_STOP) begin
                        state_d = ST_ACK;
                    end else begin
                        done_d  = ~dsync_q[1];
                        err_d   = dsync_q[1];
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            n_q     <= '0;
            rts_q   <= '0;
            wdt_q   <= '0;
            dsync_q <= 2'b11;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            n_q     <= n_d;
            rts_q   <= rts_d;
            wdt_q   <= wdt_d;
            dsync_q <= dsync_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign drv_c = (state_q == ST_RTS);
    assign drv_d = (state_q == ST_START) ||
                   ((state_q == ST_DATA) && !shift_q[0]);

    assign ps2c = drv_c ? 1'b0 : 1'bz;
    assign ps2d = drv_d ? 1'b0 : 1'bz;

    assign tx_idle      = (state_q == ST_IDLE);
    assign tx_done_tick = done_q;
    assign tx_err_tick  = err_q;

endmodule
